// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if
//   Bus between the timed-interval requesters (master side) and the shared
//   counter arbiter (slave side).
//
//   Signals
//     tick   master->slave  count enable for the running interval
//     req    master->slave  level request per requester
//     term   master->slave  terminal count per requester, slice i = [i*DW +: DW]
//     gnt    slave->master  one-hot, high while the owner's interval runs
//     done   slave->master  one-hot, one-cycle completion pulse for the owner
//     busy   slave->master  arbiter is in COUNT or DONE
//     count  slave->master  current shared counter value
//     state  slave->master  debug view of the arbiter FSM (0 IDLE, 1 COUNT, 2 DONE)
//
//   Handshake: a requester raises req[i] and holds it level; the interval is
//   accepted on the cycle gnt[i] rises, and it completes on the single cycle
//   done[i] is high. Dropping req[i] while gnt[i] is high cancels the
//   interval: gnt falls the next cycle and no done pulse is produced. req
//   from a requester that does not own the counter has no effect until the
//   arbiter is back in IDLE.
interface counter_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic                          tick;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] term;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          busy;
  logic [DATA_WIDTH-1:0]         count;
  logic [1:0]                    state;

  modport master (
    output tick, req, term,
    input  gnt, done, busy, count, state
  );

  modport slave (
    input  tick, req, term,
    output gnt, done, busy, count, state
  );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Shares one up-counter (start 0, step +1) between NUM_REQ requesters.
//   A round-robin arbiter picks one requester, latches its terminal count,
//   runs the counter on tick until it reaches that terminal, then pulses
//   done for the owner for one cycle. All outputs are registered.
//
//   Ports
//     clk  in   single clock, all state on posedge clk
//     rst  in   asynchronous active-low reset
//     bus  slave modport of counter_arbiter_if (tick/req/term in,
//          gnt/done/busy/count/state out)
module counter_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] term_q;
  logic [PTR_W-1:0]      sel_q;
  logic [PTR_W-1:0]      ptr_q;

  logic                  found_d;
  logic [PTR_W-1:0]      sel_d;
  logic [PTR_W-1:0]      ptr_d;
  logic [NUM_REQ-1:0]    gnt_d;
  logic [DATA_WIDTH-1:0] term_sel_d;

  // Round-robin pick: first set req bit at or after ptr_q, wrapping.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    found_d = 1'b0;
    sel_d   = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!found_d && bus.req[cand]) begin
        found_d = 1'b1;
        sel_d   = cand;
      end
    end
  end

  // The winner gets lowest priority in the next arbitration round.
  always_comb begin
    ptr_d = (sel_d == PTR_W'(NUM_REQ - 1)) ? '0 : sel_d + PTR_W'(1);
    gnt_d = ONE_HOT0 << sel_d;
  end

  always_comb begin
    term_sel_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_d == PTR_W'(i)) term_sel_d = bus.term[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      term_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= COUNT;
            gnt_q   <= gnt_d;
            term_q  <= term_sel_d;
            count_q <= '0;
            busy_q  <= 1'b1;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
          end
        end
        COUNT: begin
          // Cancel is checked first so it beats a same-cycle completion.
          if (!bus.req[sel_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (count_q == term_q) begin
            state_q <= DONE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
          end else if (bus.tick) begin
            count_q <= count_q + DATA_WIDTH'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  counter_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  counter_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // advance one cycle; outputs are observed 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_term(input int i, input logic [DW-1:0] v);
    bus.term[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    bus.tick = 1'b0;
    bus.req  = '0;
    bus.term = '0;
    rst      = 1'b0;
    cyc();
    checks++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); else passes++;
    checks++; if (bus.done !== 4'b0000) $display("FAIL reset_done got=%b exp=0000", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passes++;
    checks++; if (bus.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state); else passes++;
    rst = 1'b1;
    cyc();
  endtask

  // req=0001, term0=3, tick=1: gnt at 1, count 0..3 over 1..4, done at 5, IDLE at 6
  task automatic test_basic();
    logic [DW-1:0] exp_cnt [7];
    exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd0};
    set_term(0, 8'd3);
    bus.tick = 1'b1;
    bus.req  = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 5) bus.req = 4'b0000;
      checks++;
      if (bus.count !== exp_cnt[c]) $display("FAIL basic_count c=%0d got=%0d exp=%0d", c, bus.count, exp_cnt[c]); else passes++;
      checks++;
      if (bus.gnt !== ((c <= 4) ? 4'b0001 : 4'b0000)) $display("FAIL basic_gnt c=%0d got=%b", c, bus.gnt); else passes++;
      checks++;
      if (bus.done !== ((c == 5) ? 4'b0001 : 4'b0000)) $display("FAIL basic_done c=%0d got=%b", c, bus.done); else passes++;
      checks++;
      if (bus.busy !== (c <= 5)) $display("FAIL basic_busy c=%0d got=%b", c, bus.busy); else passes++;
    end
    checks++; if (bus.state !== 2'd0) $display("FAIL basic_idle got=%0d exp=0", bus.state); else passes++;
  endtask

  // term0=0: gnt at 1, done at 2, count stays 0
  task automatic test_term_zero();
    set_term(0, 8'd0);
    bus.tick = 1'b1;
    bus.req  = 4'b0001;
    cyc();
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL tz_gnt got=%b exp=0001", bus.gnt); else passes++;
    checks++; if (bus.done !== 4'b0000) $display("FAIL tz_done1 got=%b exp=0000", bus.done); else passes++;
    cyc();
    bus.req = 4'b0000;
    checks++; if (bus.done !== 4'b0001) $display("FAIL tz_done2 got=%b exp=0001", bus.done); else passes++;
    checks++; if (bus.count !== 8'd0) $display("FAIL tz_count got=%0d exp=0", bus.count); else passes++;
    cyc();
    checks++; if (bus.done !== 4'b0000) $display("FAIL tz_done3 got=%b exp=0000", bus.done); else passes++;
  endtask

  // all request, term=1 each: 4-cycle period g@1 done@3 idle@4
  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    do_reset();
    for (int i = 0; i < NR; i++) set_term(i, 8'd1);
    bus.tick = 1'b1;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % NR);
      cyc();
      checks++; if (bus.gnt !== exp_g) $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_g); else passes++;
      cyc();
      cyc();
      checks++; if (bus.done !== exp_g) $display("FAIL rr_done k=%0d got=%b exp=%b", k, bus.done, exp_g); else passes++;
      checks++; if (bus.gnt !== 4'b0000) $display("FAIL rr_gnt_off k=%0d got=%b exp=0000", k, bus.gnt); else passes++;
      cyc();
      if (k == 4) bus.req = 4'b0000;
      checks++; if (bus.done !== 4'b0000) $display("FAIL rr_pulse k=%0d got=%b exp=0000", k, bus.done); else passes++;
      checks++; if (bus.state !== 2'd0) $display("FAIL rr_idle k=%0d got=%0d exp=0", k, bus.state); else passes++;
    end
    cyc();
    checks++; if (bus.gnt !== 4'b0000) $display("FAIL rr_quiet got=%b exp=0000", bus.gnt); else passes++;
  endtask

  // drop req0 at count=2 of term0=6 -> IDLE next cycle, no done
  task automatic test_cancel();
    set_term(0, 8'd6);
    bus.tick = 1'b1;
    bus.req  = 4'b0001;
    cyc();
    cyc();
    cyc();
    checks++; if (bus.count !== 8'd2) $display("FAIL cancel_pre got=%0d exp=2", bus.count); else passes++;
    bus.req = 4'b0000;
    cyc();
    checks++; if (bus.state !== 2'd0) $display("FAIL cancel_state got=%0d exp=0", bus.state); else passes++;
    checks++; if (bus.gnt !== 4'b0000) $display("FAIL cancel_gnt got=%b exp=0000", bus.gnt); else passes++;
    checks++; if (bus.count !== 8'd0) $display("FAIL cancel_count got=%0d exp=0", bus.count); else passes++;
    checks++; if (bus.done !== 4'b0000) $display("FAIL cancel_done got=%b exp=0000", bus.done); else passes++;
    cyc();
    checks++; if (bus.done !== 4'b0000) $display("FAIL cancel_done2 got=%b exp=0000", bus.done); else passes++;
  endtask

  // tick 1,0,1,0; term change and non-owner req after grant are ignored
  task automatic test_tick_gating();
    logic [DW-1:0] exp_cnt [5];
    logic          tick_seq [5];
    exp_cnt  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    tick_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    set_term(0, 8'd6);
    bus.tick = 1'b0;
    bus.req  = 4'b0001;
    cyc();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.count !== exp_cnt[c]) $display("FAIL gate_count c=%0d got=%0d exp=%0d", c, bus.count, exp_cnt[c]); else passes++;
      checks++;
      if (bus.gnt !== 4'b0001) $display("FAIL gate_gnt c=%0d got=%b exp=0001", c, bus.gnt); else passes++;
      if (c == 2) begin
        set_term(0, 8'd1);
        bus.req = 4'b0011;
      end
      bus.tick = tick_seq[c];
      cyc();
    end
    checks++; if (bus.count !== 8'd2) $display("FAIL gate_final got=%0d exp=2", bus.count); else passes++;
    checks++; if (bus.done !== 4'b0000) $display("FAIL gate_noterm got=%b exp=0000", bus.done); else passes++;
    bus.req = 4'b0000;
    cyc();
    cyc();
  endtask

  // async reset while counting at count=5
  task automatic test_async_reset();
    set_term(0, 8'd9);
    bus.tick = 1'b1;
    bus.req  = 4'b0001;
    for (int c = 1; c <= 6; c++) cyc();
    checks++; if (bus.count !== 8'd5) $display("FAIL ar_pre got=%0d exp=5", bus.count); else passes++;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) $display("FAIL ar_gnt got=%b exp=0000", bus.gnt); else passes++;
    checks++; if (bus.done !== 4'b0000) $display("FAIL ar_done got=%b exp=0000", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL ar_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.count !== 8'd0) $display("FAIL ar_count got=%0d exp=0", bus.count); else passes++;
    bus.req = 4'b0000;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_term_zero();
    test_round_robin();
    test_cancel();
    test_tick_gating();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
